inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Responder side of the decoder's instruction-fetch handshake: accepts a held fetch request (address plus enable), returns one 32-bit little-endian instruction word with a single-cycle ready pulse, and aborts cleanly on pipeline flush. Sits between the decoder and the RAM arbiter. Misses are served from byte-wide RAM through a request/grant port, and every fetched word is kept in a small direct-mapped instruction cache.

## Interface
- ICACHE_IDX_W, 6: cache index width; the cache holds 2^ICACHE_IDX_W words.
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-high.
- rdy_in  input  1  global enable; low freezes the block.
- flush  input  1  misprediction flush; acted on only when rdy_in is high.
- if_en  input  1  fetch request from the decoder; held high with a stable address until if_rdy.
- if_addr  input  32  fetch address; bits [1:0] are ignored.
- if_rdy  output  1  one-cycle pulse; if_data is valid in that cycle.
- if_data  output  32  instruction word, little-endian assembled.
- mem_req  output  1  request for the RAM port.
- mem_gnt  input  1  arbiter grant this cycle; mem_a is sampled by RAM.
- mem_a  output  32  byte address to RAM.
- mem_din  input  8  RAM read byte; valid the cycle after a granted request.

## Operation
- Reset values: if_rdy=0, if_data=0, mem_req=0, mem_a=0, state=IDLE, all cache valid bits cleared.
- Address split:
  - index = if_addr[ICACHE_IDX_W+1:2];
  - tag = if_addr[31:ICACHE_IDX_W+2].
- States and transitions:
  - IDLE: if if_en is high and flush is low, latch the word address.
    - Hit: set if_data to the cached word, if_rdy<=1, go to DONE.
    - Miss: clear the issue and receive counters, go to READ.
  - READ: mem_req is high while issue_cnt<4.
    - mem_a = latched address + issue_cnt.
    - issue_cnt increments on each mem_gnt.
    - A byte is captured into lane recv_cnt the cycle after each grant, then recv_cnt increments.
    - When recv_cnt reaches 4: write data, tag and valid into the cache at the index, then go to FILL.
  - FILL: if if_en is still high, drive if_data with the assembled word and set if_rdy<=1, then go to DONE. If if_en is low, go to IDLE with no pulse.
  - DONE: if_rdy<=0 and go to IDLE. if_en is ignored in this state, which prevents re-serving the already-answered request.
- Flush (with rdy_in high) has priority over everything:
  - state<=IDLE, if_rdy<=0, mem_req low from the next cycle;
  - in-flight bytes are discarded and the cache is not written;
  - valid bits are kept.
- rdy_in low:
  - all state is held and mem_req is forced low;
  - the only exception is the byte return of a grant issued the previous cycle, which is still captured.
- Cache contents are never invalidated except by reset, because code is not self-modifying.

## Timing
- Hit: if_en sampled high at the end of cycle 0; if_rdy high in cycle 1.
- Miss with continuous grant:
  - mem_a carries addr+0..addr+3 in cycles 1–4;
  - bytes arrive in cycles 2–5;
  - cache write happens at the end of cycle 5 (READ→FILL);
  - if_rdy is high in cycle 7.
- Each cycle without a grant delays completion by one cycle.
- if_rdy is never high on two consecutive cycles.
- At most one request is outstanding.

## Structure
- params.v gains:
  - ICACHE_IDX_W default;
  - the fetch state encodings (IDLE, READ, FILL, DONE).
- Sub-module icache_array:
  - valid, tag and data storage;
  - combinational lookup (index/tag in, hit/word out);
  - synchronous write port;
  - asynchronous clear of valid bits on rst_in.
- The top level holds the state machine, counters and byte assembly.

## Test plan
- Cold miss:
  - Stimulus: RAM bytes 0x13,0x05,0x10,0x00 at addr 0; if_en with if_addr=0; mem_gnt tied high.
  - Expected: if_rdy pulses in cycle 7 with if_data=0x00100513; mem_a sequence 0,1,2,3.
- Hit after fill:
  - Stimulus: re-request address 0.
  - Expected: if_rdy in cycle 1, mem_req never asserted.
- Conflict miss:
  - Stimulus: fetch 0x100 with ICACHE_IDX_W=6, which maps to the same index as 0.
  - Expected: a miss; a later fetch of 0 also misses.
- Flush mid-fill:
  - Stimulus: assert flush after the 2nd byte, then if_en at 0x40.
  - Expected: no if_rdy for the old address; 0x40 is fetched correctly; the old line is not valid.
- Stalls:
  - Stimulus: mem_gnt low on alternate cycles, plus rdy_in low for 3 cycles mid-READ.
  - Expected: the correct word returns, latency is extended by exactly the stall cycles, and if_rdy stays single-cycle.
- Async reset mid-READ:
  - Expected: outputs go to their reset values immediately, and a subsequent fetch misses.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl_pkg
// Brief    : Shared types and constants for the instruction-fetch responder.
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_ctrl_pkg;

  // Default cache index width; the cache holds 2**ICACHE_IDX_W words.
  localparam int ICACHE_IDX_W_DEFAULT = 6;

  // Number of RAM bytes assembled into one instruction word.
  localparam logic [2:0] BYTES_PER_WORD = 3'd4;

  // Fetch state encodings.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  // Instruction addresses are word aligned; the two low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl_if
// Brief    : Fetch handshake (decoder side) and byte-RAM request/grant port.
//            master = environment (decoder + arbiter/RAM),
//            slave  = the fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_ctrl_if;
  logic        flush;
  logic        if_en;
  logic [31:0] if_addr;
  logic        if_rdy;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;

  modport master (
    output flush, if_en, if_addr, mem_gnt, mem_din,
    input  if_rdy, if_data, mem_req, mem_a
  );

  modport slave (
    input  flush, if_en, if_addr, mem_gnt, mem_din,
    output if_rdy, if_data, mem_req, mem_a
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_ctrl_icache_array.sv
`default_nettype none
// ============================================================================
// Module   : icache_array
// Brief    : Direct-mapped instruction cache storage. Combinational lookup,
//            synchronous write, valid bits cleared only by reset.
// Revision : 1.0 - initial release
// ============================================================================
module icache_array
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W_DEFAULT
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic [IDX_W-1:0]    rd_idx,
  input  wire logic [29-IDX_W:0]   rd_tag,
  output      logic                rd_hit,
  output      logic [31:0]         rd_word,
  input  wire logic                wr_en,
  input  wire logic [IDX_W-1:0]    wr_idx,
  input  wire logic [29-IDX_W:0]   wr_tag,
  input  wire logic [31:0]         wr_word
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [DEPTH];
  logic [31:0]      r_data [DEPTH];

  // Valid bits: cleared asynchronously by reset, set on each line fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (wr_en) begin
      r_valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage are plain memories with no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_tag[wr_idx]  <= wr_tag;
      r_data[wr_idx] <= wr_word;
    end
  end

  assign rd_hit  = r_valid[rd_idx] && (r_tag[rd_idx] == rd_tag);
  assign rd_word = r_data[rd_idx];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl
// Brief    : Instruction-fetch responder. Serves hits from a direct-mapped
//            cache in one cycle; misses read four bytes from RAM over a
//            request/grant port, assemble a little-endian word and fill
//            the cache. Flush aborts any fetch in progress.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int ICACHE_IDX_W = ICACHE_IDX_W_DEFAULT
) (
  input  wire logic         clk_in,
  input  wire logic         rst_in,
  input  wire logic         rdy_in,
  inst_fetch_ctrl_if.slave  bus
);

  localparam int TAG_W = 30 - ICACHE_IDX_W;

  fetch_state_t           r_state;
  logic [31:0]            r_addr;
  logic [2:0]             r_issue_cnt;
  logic [2:0]             r_recv_cnt;
  logic                   r_pend;
  logic [3:0][7:0]        r_bytes;
  logic                   r_if_rdy;
  logic [31:0]            r_if_data;
  logic                   r_mem_req;
  logic [31:0]            r_mem_a;

  logic                   w_hit;
  logic [31:0]            w_hit_word;
  logic                   w_flush;
  logic                   w_grant;
  logic                   w_capture;
  logic                   w_fill_done;
  logic                   w_cache_we;
  logic [3:0][7:0]        w_fill_word;

  // A flush only counts while the block is enabled.
  assign w_flush     = rdy_in & bus.flush;
  // A grant is honoured only for a request actually visible on the port.
  assign w_grant     = r_mem_req & rdy_in & bus.mem_gnt;
  // The byte for last cycle's grant is captured even if rdy_in has dropped.
  assign w_capture   = r_pend && (r_recv_cnt < BYTES_PER_WORD);
  // Line is complete once four bytes are in, counting the one arriving now.
  assign w_fill_done = (r_recv_cnt == BYTES_PER_WORD) ||
                       (r_pend && (r_recv_cnt == BYTES_PER_WORD - 3'd1));
  assign w_cache_we  = rdy_in && !bus.flush && (r_state == READ) && w_fill_done;

  // Merge the byte arriving this cycle so the cache write sees the full word.
  always_comb begin
    w_fill_word = r_bytes;
    if (w_capture) begin
      w_fill_word[r_recv_cnt[1:0]] = bus.mem_din;
    end
  end

  icache_array #(
    .IDX_W (ICACHE_IDX_W)
  ) u_icache (
    .clk     (clk_in),
    .rst     (rst_in),
    .rd_idx  (bus.if_addr[ICACHE_IDX_W+1:2]),
    .rd_tag  (bus.if_addr[31:ICACHE_IDX_W+2]),
    .rd_hit  (w_hit),
    .rd_word (w_hit_word),
    .wr_en   (w_cache_we),
    .wr_idx  (r_addr[ICACHE_IDX_W+1:2]),
    .wr_tag  (r_addr[31:ICACHE_IDX_W+2]),
    .wr_word (w_fill_word)
  );

  // Fetch state machine, RAM counters, byte assembly and registered outputs.
  // if_rdy is cleared every cycle so it stays a single-cycle pulse even
  // when rdy_in holds the rest of the state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_pend      <= 1'b0;
      r_bytes     <= '0;
      r_if_rdy    <= 1'b0;
      r_if_data   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_a     <= '0;
    end else begin
      r_if_rdy <= 1'b0;
      if (w_flush) begin
        // Abandon the fetch; in-flight bytes are dropped, cache untouched.
        r_state   <= IDLE;
        r_mem_req <= 1'b0;
        r_pend    <= 1'b0;
      end else begin
        if (w_capture) begin
          r_bytes[r_recv_cnt[1:0]] <= bus.mem_din;
          r_recv_cnt               <= r_recv_cnt + 3'd1;
        end
        r_pend <= w_grant;
        if (rdy_in) begin
          case (r_state)
            IDLE: begin
              if (bus.if_en) begin
                r_addr <= word_align(bus.if_addr);
                if (w_hit) begin
                  r_if_data <= w_hit_word;
                  r_if_rdy  <= 1'b1;
                  r_state   <= DONE;
                end else begin
                  r_issue_cnt <= '0;
                  r_recv_cnt  <= '0;
                  r_mem_req   <= 1'b1;
                  r_mem_a     <= word_align(bus.if_addr);
                  r_state     <= READ;
                end
              end
            end
            READ: begin
              if (w_grant) begin
                r_issue_cnt <= r_issue_cnt + 3'd1;
                r_mem_a     <= r_addr + {29'd0, r_issue_cnt + 3'd1};
                if (r_issue_cnt == BYTES_PER_WORD - 3'd1) begin
                  r_mem_req <= 1'b0;
                end
              end
              if (w_fill_done) begin
                r_state <= FILL;
              end
            end
            FILL: begin
              if (bus.if_en) begin
                r_if_data <= r_bytes;
                r_if_rdy  <= 1'b1;
                r_state   <= DONE;
              end else begin
                r_state <= IDLE;
              end
            end
            DONE: begin
              r_state <= IDLE;
            end
            default: begin
              r_state <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign bus.if_rdy  = r_if_rdy;
  assign bus.if_data = r_if_data;
  assign bus.mem_req = r_mem_req & rdy_in;
  assign bus.mem_a   = r_mem_a;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_ctrl
// Brief    : Self-checking bench for inst_fetch_ctrl: a table of fetches,
//            directed flush/stall/reset sequences and random fetches
//            checked against a RAM image and a direct-mapped cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl #(
    .ICACHE_IDX_W (6)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]  ram [4096];
  logic        s_rdy, s_req;
  logic [31:0] s_data, s_a;
  logic [31:0] gq[$];

  // Cache model: what the fetch rules say should be resident.
  bit          mv [64];
  logic [23:0] mt [64];

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    int          lat;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[12];

  function automatic logic [31:0] ram_word(input logic [31:0] addr);
    logic [11:0] a;
    a = addr[11:0] & 12'hFFC;
    return {ram[a + 12'd3], ram[a + 12'd2], ram[a + 12'd1], ram[a]};
  endfunction

  function automatic bit model_hit(input logic [31:0] addr);
    return mv[addr[7:2]] && (mt[addr[7:2]] == addr[31:8]);
  endfunction

  function automatic void model_note(input logic [31:0] addr);
    mv[addr[7:2]] = 1'b1;
    mt[addr[7:2]] = addr[31:8];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample mid-cycle, then present the RAM byte for any grant.
  task automatic step();
    logic        g;
    logic [31:0] ga;
    @(negedge clk);
    s_rdy  = bus.if_rdy;
    s_data = bus.if_data;
    s_req  = bus.mem_req;
    s_a    = bus.mem_a;
    g      = bus.mem_req && bus.mem_gnt;
    ga     = bus.mem_a;
    if (g) gq.push_back(ga);
    @(posedge clk);
    #1;
    bus.mem_din = g ? ram[ga[11:0]] : 8'($urandom);
  endtask

  // Per-cycle environment: 0 = ideal, 1 = fixed stall pattern, 2 = random.
  task automatic drive(input int mode, input int n);
    case (mode)
      1: begin
        rdy         = !(n >= 4 && n <= 6);
        bus.mem_gnt = (n % 2 == 1);
      end
      2: begin
        rdy         = ($urandom_range(0, 3) != 0);
        bus.mem_gnt = 1'($urandom_range(0, 1));
      end
      default: begin
        rdy         = 1'b1;
        bus.mem_gnt = 1'b1;
      end
    endcase
  endtask

  task automatic fetch(input logic [31:0] addr, input int mode, output int lat,
                       output logic [31:0] data, output bit saw_req, output int first_rdy);
    gq.delete();
    lat       = -1;
    data      = '0;
    saw_req   = 1'b0;
    first_rdy = -1;
    bus.if_en   = 1'b1;
    bus.if_addr = addr;
    drive(mode, 0);
    if (rdy && first_rdy < 0) first_rdy = 0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (s_req) saw_req = 1'b1;
      if (s_rdy) begin
        lat  = n;
        data = s_data;
        break;
      end
      drive(mode, n + 1);
      if (rdy && first_rdy < 0) first_rdy = n + 1;
    end
    bus.if_en   = 1'b0;
    bus.if_addr = $urandom;
    rdy         = 1'b1;
    bus.mem_gnt = 1'b1;
    if (lat < 0) begin
      n_checks++;
      n_err++;
      $display("FAIL fetch_timeout: addr %h got no if_rdy within 200 cycles", addr);
    end else begin
      step();
      chk("if_rdy_single_pulse", {31'd0, s_rdy}, 32'd0);
    end
  endtask

  task automatic check_grants(input string nm, input logic [31:0] addr, input bit miss);
    int exp_n;
    exp_n = miss ? 4 : 0;
    chk({nm, "_grant_count"}, 32'(gq.size()), 32'(exp_n));
    for (int k = 0; k < gq.size() && k < 4; k++)
      chk({nm, "_mem_a"}, gq[k], (addr & 32'hFFFF_FFFC) + 32'(k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, fr;
    logic [31:0] data;
    bit          sreq;
    logic [31:0] a;
    bit          ph;

    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 37 + 11) ^ 8'(i >> 8);
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;
    model_clear();

    rst = 1'b1; rdy = 1'b1;
    bus.flush = 1'b0; bus.if_en = 1'b0; bus.if_addr = '0;
    bus.mem_gnt = 1'b1; bus.mem_din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_if_rdy",  {31'd0, bus.if_rdy},  32'd0);
    chk("reset_if_data", bus.if_data,          32'd0);
    chk("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("reset_mem_a",   bus.mem_a,            32'd0);
    rst = 1'b0;

    // ---------------- table-driven fetches, ideal RAM port ----------------
    vecs[0]  = '{32'h0000_0000, 1'b0, 7, 32'h0010_0513};
    vecs[1]  = '{32'h0000_0000, 1'b1, 1, 32'h0010_0513};
    vecs[2]  = '{32'h0000_0004, 1'b0, 7, ram_word(32'h4)};
    vecs[3]  = '{32'h0000_0100, 1'b0, 7, ram_word(32'h100)};
    vecs[4]  = '{32'h0000_0004, 1'b1, 1, ram_word(32'h4)};
    vecs[5]  = '{32'h0000_0000, 1'b0, 7, 32'h0010_0513};
    vecs[6]  = '{32'h0000_0100, 1'b0, 7, ram_word(32'h100)};
    vecs[7]  = '{32'h0000_00FC, 1'b0, 7, ram_word(32'hFC)};
    vecs[8]  = '{32'h0000_00FE, 1'b1, 1, ram_word(32'hFC)};
    vecs[9]  = '{32'hFFFF_FFFC, 1'b0, 7, ram_word(32'hFFFF_FFFC)};
    vecs[10] = '{32'h0000_00FC, 1'b0, 7, ram_word(32'hFC)};
    vecs[11] = '{32'hFFFF_FFFF, 1'b0, 7, ram_word(32'hFFFF_FFFC)};
    for (int v = 0; v < 12; v++) begin
      fetch(vecs[v].addr, 0, lat, data, sreq, fr);
      chk($sformatf("vec%0d_data", v), data, vecs[v].data);
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      chk($sformatf("vec%0d_mem_req_seen", v), {31'd0, sreq}, {31'd0, !vecs[v].hit});
      check_grants($sformatf("vec%0d", v), vecs[v].addr, !vecs[v].hit);
      model_note(vecs[v].addr);
    end

    // ---------------- flush after the second byte ----------------
    gq.delete();
    bus.if_en = 1'b1; bus.if_addr = 32'h80; rdy = 1'b1; bus.mem_gnt = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("flush_seq_no_rdy", {31'd0, s_rdy}, 32'd0);
    end
    bus.flush = 1'b1; bus.if_en = 1'b0;
    step();
    chk("flush_cycle_no_rdy", {31'd0, s_rdy}, 32'd0);
    bus.flush = 1'b0;
    step();
    chk("after_flush_mem_req", {31'd0, s_req}, 32'd0);
    chk("after_flush_no_rdy",  {31'd0, s_rdy}, 32'd0);
    fetch(32'h40, 0, lat, data, sreq, fr);
    chk("flush_new_data",    data,       ram_word(32'h40));
    chk("flush_new_latency", 32'(lat),   32'd7);
    check_grants("flush_new", 32'h40, 1'b1);
    model_note(32'h40);
    fetch(32'h80, 0, lat, data, sreq, fr);
    chk("flush_old_misses", {31'd0, sreq}, 32'd1);
    chk("flush_old_data",   data,          ram_word(32'h80));
    chk("flush_old_latency", 32'(lat),     32'd7);
    model_note(32'h80);

    // ---- stalls: grant on odd cycles, rdy_in low in cycles 4..6 ----
    // Five lost cycles (no grant in 2 and 8, disabled in 4..6) on top of 7.
    fetch(32'h2C0, 1, lat, data, sreq, fr);
    chk("stall_data",    data,     ram_word(32'h2C0));
    chk("stall_latency", 32'(lat), 32'd12);
    check_grants("stall", 32'h2C0, 1'b1);
    model_note(32'h2C0);
    fetch(32'h2C0, 0, lat, data, sreq, fr);
    chk("stall_rehit_latency", 32'(lat), 32'd1);

    // ---------------- asynchronous reset in the middle of READ ----------------
    bus.if_en = 1'b1; bus.if_addr = 32'h340; rdy = 1'b1; bus.mem_gnt = 1'b1;
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("async_rst_mem_a",   bus.mem_a,            32'd0);
    chk("async_rst_if_rdy",  {31'd0, bus.if_rdy},  32'd0);
    chk("async_rst_if_data", bus.if_data,          32'd0);
    bus.if_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    fetch(32'h0, 0, lat, data, sreq, fr);
    chk("post_rst_miss",    {31'd0, sreq}, 32'd1);
    chk("post_rst_latency", 32'(lat),      32'd7);
    chk("post_rst_data",    data,          32'h0010_0513);
    model_note(32'h0);

    // ---------------- random fetches against the cache model ----------------
    for (int t = 0; t < 40; t++) begin
      a  = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      ph = model_hit(a);
      fetch(a, 2, lat, data, sreq, fr);
      chk("rand_data", data, ram_word(a));
      chk("rand_hit_miss", {31'd0, sreq}, {31'd0, !ph});
      if (ph) chk("rand_hit_latency", 32'(lat), 32'(fr + 1));
      check_grants("rand", a, !ph);
      model_note(a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
